// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-step shift-add multiplier / restoring divider driving HI/LO
module muldiv_unit #(
    parameter int bit_size = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [1:0]          i_md_op,
    input  logic [bit_size-1:0] i_src1,
    input  logic [bit_size-1:0] i_src2,
    input  logic                i_hi_we,
    input  logic                i_lo_we,
    output logic                o_busy,
    output logic                o_done,
    output logic [bit_size-1:0] o_hi,
    output logic [bit_size-1:0] o_lo
);
    localparam int W = bit_size;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]     r_state;
    logic [5:0]     r_cnt;
    logic           r_div;
    logic           r_neg;
    logic           r_neg_r;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic           r_done;

    logic           w_signed;
    logic           w_dz;
    logic           w_s1;
    logic           w_s2;
    logic [W-1:0]   w_op1;
    logic [W-1:0]   w_op2;
    logic [W:0]     w_sum;
    logic [W:0]     w_rsh;
    logic           w_ge;
    logic [W-1:0]   w_rdiff;
    logic [W-1:0]   w_rem;
    logic [2*W-1:0] w_prod_fix;
    logic [W-1:0]   w_q_fix;
    logic [W-1:0]   w_r_fix;

    // Operand conditioning at launch: magnitudes for signed ops; a zero divisor keeps the raw
    // dividend so the restoring loop naturally leaves remainder = src1 and quotient = all ones.
    always_comb begin
        w_signed = ~i_md_op[0];
        w_dz     = i_md_op[1] & (i_src2 == '0);
        w_s1     = w_signed & i_src1[W-1];
        w_s2     = w_signed & i_src2[W-1];
        w_op1    = (w_s1 && !w_dz) ? -i_src1 : i_src1;
        w_op2    = w_s2 ? -i_src2 : i_src2;
    end

    // One iteration step: shift-add for multiply, shift/trial-subtract for divide.
    always_comb begin
        w_sum   = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_b[0] ? r_a : {W{1'b0}})};
        w_rsh   = {r_acc[2*W-1:W], r_a[W-1]};
        w_ge    = w_rsh >= {1'b0, r_b};
        w_rdiff = w_rsh[W-1:0] - r_b;
        w_rem   = w_ge ? w_rdiff : w_rsh[W-1:0];
    end

    // Sign correction applied in FIX: product/quotient by sign xor, remainder by dividend sign.
    always_comb begin
        w_prod_fix = r_neg ? -r_acc : r_acc;
        w_q_fix    = r_neg ? -r_acc[W-1:0] : r_acc[W-1:0];
        w_r_fix    = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
    end

    // Control FSM, iteration datapath and HI/LO registers; reset aborts any operation in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_neg   <= 1'b0;
            r_neg_r <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    if (i_hi_we) r_hi <= i_src1;
                    if (i_lo_we) r_lo <= i_src1;
                    if (i_start) begin
                        r_div   <= i_md_op[1];
                        r_neg   <= (w_s1 ^ w_s2) & ~w_dz;
                        r_neg_r <= i_md_op[1] & w_s1 & ~w_dz;
                        r_a     <= w_op1;
                        r_b     <= w_op2;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_div) begin
                        r_acc <= {w_rem, r_acc[W-2:0], w_ge};
                        r_a   <= {r_a[W-2:0], 1'b0};
                    end else begin
                        r_acc <= {w_sum, r_acc[W-1:1]};
                        r_b   <= {1'b0, r_b[W-1:1]};
                    end
                    if (r_cnt == 6'(W - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi    <= r_div ? w_r_fix : w_prod_fix[2*W-1:W];
                    r_lo    <= r_div ? w_q_fix : w_prod_fix[W-1:0];
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
endmodule
